// File: rtl/mc_boot_loader.sv
// mc_boot_loader: receives a big-endian word image over a byte valid/ready stream,
// writes it to CPU memory and releases the CPU reset once loaded. MC_BOOT_CHKSUM_EN adds a trailing XOR checksum byte.
module mc_boot_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic              o_mem_we,
  output logic [31:0]       o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_cpu_rst_n,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W:0]   o_words
);

  // state    | meaning
  // S_LEN_HI | waiting for word-count high byte
  // S_LEN_LO | waiting for word-count low byte, then range check
  // S_DATA   | collecting the 4 bytes of the current word
  // S_WRITE  | single-cycle memory write of the assembled word
  // S_CHK    | waiting for the checksum byte (checksum build only)
  // S_DONE   | image loaded, CPU released (terminal)
  // S_ERR    | protocol error, CPU held in reset (terminal)
  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
`ifdef MC_BOOT_CHKSUM_EN
    , S_CHK
`endif
  } state_t;

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

  state_t          state_q, state_d;
  logic [15:0]     len_q, len_d;
  logic [1:0]      bidx_q, bidx_d;
  logic [31:0]     word_q, word_d;
  logic [ADDR_W:0] words_q, words_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            ready_q, ready_d;
  logic            we_q, we_d;
  logic            cpu_rst_n_q, cpu_rst_n_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
`ifdef MC_BOOT_CHKSUM_EN
  logic [7:0]      xor_q, xor_d;
`endif

  logic        xfer;
  logic [31:0] words_inc;
  state_t      end_state;

  assign xfer      = i_byte_valid & ready_q;
  assign words_inc = 32'(words_q) + 32'd1;
`ifdef MC_BOOT_CHKSUM_EN
  assign end_state = S_CHK;
`else
  assign end_state = S_DONE;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    bidx_d  = bidx_q;
    word_d  = word_q;
    words_d = words_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef MC_BOOT_CHKSUM_EN
    xor_d   = xor_q;
`endif
    case (state_q)
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = i_byte;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = i_byte;
          if (len_d == 16'd0) begin
            state_d = end_state;
          end else if ({16'h0000, len_d} > MAX_WORDS) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d = {word_q[23:0], i_byte};
          bidx_d = bidx_q + 2'd1;
`ifdef MC_BOOT_CHKSUM_EN
          xor_d  = xor_q ^ i_byte;
`endif
          // Address and data are latched here so they are valid during the S_WRITE cycle.
          if (bidx_q == 2'd3) begin
            state_d = S_WRITE;
            addr_d  = BASE_ADDR + 32'({words_q[ADDR_W-1:0], 2'b00});
            wdata_d = word_d;
          end
        end
      end
      S_WRITE: begin
        words_d = words_q + {{ADDR_W{1'b0}}, 1'b1};
        if (words_inc == {16'h0000, len_q}) begin
          state_d = end_state;
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef MC_BOOT_CHKSUM_EN
      S_CHK: begin
        if (xfer) begin
          state_d = (i_byte == xor_q) ? S_DONE : S_ERR;
        end
      end
`endif
      default: ;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    ready_d     = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) || (state_d == S_DATA)
`ifdef MC_BOOT_CHKSUM_EN
                  || (state_d == S_CHK)
`endif
                  ;
    we_d        = (state_d == S_WRITE);
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
    cpu_rst_n_d = (state_d == S_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_LEN_HI;
      len_q       <= 16'd0;
      bidx_q      <= 2'd0;
      word_q      <= 32'd0;
      words_q     <= '0;
      addr_q      <= BASE_ADDR;
      wdata_q     <= 32'd0;
      ready_q     <= 1'b1;
      we_q        <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef MC_BOOT_CHKSUM_EN
      xor_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      bidx_q      <= bidx_d;
      word_q      <= word_d;
      words_q     <= words_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef MC_BOOT_CHKSUM_EN
      xor_q       <= xor_d;
`endif
    end
  end

  assign o_byte_ready = ready_q;
  assign o_mem_we     = we_q;
  assign o_mem_addr   = addr_q;
  assign o_mem_wdata  = wdata_q;
  assign o_cpu_rst_n  = cpu_rst_n_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_words      = words_q;

endmodule

// File: tb/tb_mc_boot_loader.sv
// tb_mc_boot_loader: randomized self-checking bench for mc_boot_loader against a stream-level model.
module tb_mc_boot_loader;
  localparam int ADDR_W = 8;
`ifdef MC_BOOT_CHKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic [7:0]      i_byte = 8'h00;
  logic            i_byte_valid = 1'b0;
  logic            o_byte_ready, o_mem_we, o_cpu_rst_n, o_done, o_err;
  logic [31:0]     o_mem_addr, o_mem_wdata;
  logic [ADDR_W:0] o_words;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  mc_boot_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h0000_0000)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
    .o_byte_ready(o_byte_ready), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_cpu_rst_n(o_cpu_rst_n), .o_done(o_done),
    .o_err(o_err), .o_words(o_words)
  );

  // write monitor
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int cyc = 0, last_we_cyc = -1, rst_rise_cyc = -1, we_ready_viol = 0;

  always @(negedge i_clk) begin
    cyc++;
    if (o_mem_we) begin
      wr_addr.push_back(o_mem_addr);
      wr_data.push_back(o_mem_wdata);
      last_we_cyc = cyc;
      if (o_byte_ready) we_ready_viol++;
    end
    if (o_cpu_rst_n && rst_rise_cyc < 0) rst_rise_cyc = cyc;
  end

  // reference model: expected writes and final status from the byte stream alone
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  bit exp_done, exp_err;
  int exp_words;

  task automatic model(input logic [7:0] s[$]);
    int n;
    logic [7:0] x;
    exp_addr.delete(); exp_data.delete();
    exp_done = 0; exp_err = 0; exp_words = 0; x = 8'h00;
    n = int'(s[0]) * 256 + int'(s[1]);
    if (n > (1 << ADDR_W)) begin
      exp_err = 1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(32'(4 * i));
      exp_data.push_back({s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]});
      x = x ^ s[2+4*i] ^ s[3+4*i] ^ s[4+4*i] ^ s[5+4*i];
    end
    exp_words = n;
    if (CHK_EN && s[2+4*n] != x) exp_err = 1;
    else exp_done = 1;
  endtask

  task automatic add_chk(inout logic [7:0] s[$]);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 2; i < s.size(); i++) x = x ^ s[i];
    if (CHK_EN) s.push_back(x);
  endtask

  task automatic build(input int n, output logic [7:0] s[$]);
    s.delete();
    s.push_back(8'(n >> 8));
    s.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
    add_chk(s);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_byte_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    wr_addr.delete(); wr_data.delete();
    rst_rise_cyc = -1; last_we_cyc = -1; we_ready_viol = 0;
    i_rst_n = 1'b1;
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int gap_min, input int gap_max, output bit ok);
    int n;
    ok = 1;
    foreach (s[i]) begin
      repeat ($urandom_range(gap_max, gap_min)) begin
        @(negedge i_clk);
        i_byte_valid = 1'b0;
      end
      @(negedge i_clk);
      i_byte_valid = 1'b1;
      i_byte = s[i];
      n = 0;
      while (!o_byte_ready && n < 100) begin
        @(negedge i_clk);
        n++;
      end
      if (!o_byte_ready) begin
        ok = 0;
        break;
      end
      @(posedge i_clk);
    end
    @(negedge i_clk);
    i_byte_valid = 1'b0;
  endtask

  task automatic wait_end(output bit ok);
    int n;
    n = 0;
    while (!(o_done || o_err) && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    ok = o_done || o_err;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #2;
    checks++;
    if ({o_byte_ready, o_mem_we, o_cpu_rst_n, o_done, o_err} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags got=%b want=10000", {o_byte_ready, o_mem_we, o_cpu_rst_n, o_done, o_err});
    end
    checks++;
    if (o_mem_addr !== 32'h0 || o_mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr_data got=%h/%h want=0/0", o_mem_addr, o_mem_wdata);
    end
    checks++;
    if (o_words !== '0) begin
      errors++;
      $display("FAIL reset_words got=%0d want=0", o_words);
    end
  endtask

  task automatic test_basic(input string name, input int gap);
    logic [7:0] s[$];
    bit ok, ok2;
    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    add_chk(s);
    model(s);
    do_reset();
    send_stream(s, gap, gap, ok);
    wait_end(ok2);
    checks++;
    if (!(ok && ok2)) begin
      errors++;
      $display("FAIL %s_handshake got=%0d%0d want=11", name, ok, ok2);
    end
    checks++;
    if (wr_addr.size() != 2 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h12345678 ||
        wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h9ABCDEF0) begin
      errors++;
      $display("FAIL %s_writes got n=%0d want (0,12345678)(4,9abcdef0)", name, wr_addr.size());
    end
    checks++;
    if ({o_done, o_err, o_cpu_rst_n} !== {exp_done, exp_err, exp_done} || o_words !== (ADDR_W+1)'(exp_words)) begin
      errors++;
      $display("FAIL %s_status got done=%b err=%b cpu=%b words=%0d want %b %b %b %0d",
               name, o_done, o_err, o_cpu_rst_n, o_words, exp_done, exp_err, exp_done, exp_words);
    end
    checks++;
    if (we_ready_viol != 0) begin
      errors++;
      $display("FAIL %s_ready_in_write got=%0d want=0", name, we_ready_viol);
    end
`ifndef MC_BOOT_CHKSUM_EN
    checks++;
    if (rst_rise_cyc - last_we_cyc != 1) begin
      errors++;
      $display("FAIL %s_rst_latency got=%0d want=1", name, rst_rise_cyc - last_we_cyc);
    end
`endif
  endtask

  task automatic test_zero();
    logic [7:0] s[$];
    bit ok, ok2;
    s = '{8'h00, 8'h00};
    add_chk(s);
    do_reset();
    send_stream(s, 0, 0, ok);
    wait_end(ok2);
    checks++;
    if (!(ok && ok2) || wr_addr.size() != 0 || {o_done, o_err, o_cpu_rst_n} !== 3'b101 || o_words !== '0) begin
      errors++;
      $display("FAIL zero_len got ok=%0d%0d writes=%0d done=%b err=%b cpu=%b want 11 0 1 0 1",
               ok, ok2, wr_addr.size(), o_done, o_err, o_cpu_rst_n);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] s[$];
    bit ok, ok2;
    int rdy;
    s = '{8'h01, 8'h01};
    model(s);
    do_reset();
    send_stream(s, 0, 0, ok);
    wait_end(ok2);
    checks++;
    if ({o_err, o_done, o_cpu_rst_n} !== {exp_err, 1'b0, 1'b0} || wr_addr.size() != 0) begin
      errors++;
      $display("FAIL overflow_status got err=%b done=%b cpu=%b writes=%0d want 1 0 0 0",
               o_err, o_done, o_cpu_rst_n, wr_addr.size());
    end
    rdy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      i_byte_valid = 1'b1;
      i_byte = 8'($urandom);
      #1;
      if (o_byte_ready) rdy++;
    end
    @(negedge i_clk);
    i_byte_valid = 1'b0;
    checks++;
    if (rdy != 0 || wr_addr.size() != 0 || o_words !== '0) begin
      errors++;
      $display("FAIL overflow_ignore got ready_cycles=%0d writes=%0d want 0 0", rdy, wr_addr.size());
    end
  endtask

  task automatic test_abort();
    logic [7:0] s[$];
    logic [7:0] part[$];
    bit ok, ok2;
    build(2, s);
    part = s[0:7];
    do_reset();
    send_stream(part, 0, 1, ok);
    repeat (3) @(negedge i_clk);
    checks++;
    if (!ok || wr_addr.size() != 1 || wr_data[0] !== {s[2], s[3], s[4], s[5]} || o_words !== (ADDR_W+1)'(1)) begin
      errors++;
      $display("FAIL abort_partial got ok=%0d writes=%0d words=%0d want 1 1 1", ok, wr_addr.size(), o_words);
    end
    @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_words !== '0 || o_cpu_rst_n !== 1'b0 || o_byte_ready !== 1'b1 || o_mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL abort_async got words=%0d cpu=%b ready=%b want 0 0 1", o_words, o_cpu_rst_n, o_byte_ready);
    end
    s = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    add_chk(s);
    do_reset();
    send_stream(s, 0, 0, ok);
    wait_end(ok2);
    checks++;
    if (!(ok && ok2) || wr_addr.size() != 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hAABBCCDD ||
        o_words !== (ADDR_W+1)'(1) || o_done !== 1'b1) begin
      errors++;
      $display("FAIL abort_reload got writes=%0d words=%0d done=%b want (0,aabbccdd) 1 1",
               wr_addr.size(), o_words, o_done);
    end
  endtask

  task automatic test_random(input int iters);
    logic [7:0] s[$];
    bit ok, ok2;
    int bad;
    for (int it = 0; it < iters; it++) begin
      build($urandom_range(8, 1), s);
      if (CHK_EN && $urandom_range(1, 0) == 1) s[s.size()-1] = s[s.size()-1] ^ 8'h5A;
      model(s);
      do_reset();
      send_stream(s, 0, 2, ok);
      wait_end(ok2);
      bad = 0;
      for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++)
        if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) bad++;
      checks++;
      if (!(ok && ok2) || bad != 0 || wr_addr.size() != exp_addr.size()) begin
        errors++;
        $display("FAIL random_%0d_writes got n=%0d bad=%0d want n=%0d bad=0", it, wr_addr.size(), bad, exp_addr.size());
      end
      checks++;
      if ({o_done, o_err, o_cpu_rst_n} !== {exp_done, exp_err, exp_done} || o_words !== (ADDR_W+1)'(exp_words)) begin
        errors++;
        $display("FAIL random_%0d_status got %b%b%b words=%0d want %b%b%b words=%0d",
                 it, o_done, o_err, o_cpu_rst_n, o_words, exp_done, exp_err, exp_done, exp_words);
      end
    end
  endtask

  task automatic test_max();
    logic [7:0] s[$];
    bit ok, ok2;
    int bad;
    build(1 << ADDR_W, s);
    model(s);
    do_reset();
    send_stream(s, 0, 0, ok);
    wait_end(ok2);
    bad = 0;
    for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++)
      if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) bad++;
    checks++;
    if (!(ok && ok2) || bad != 0 || wr_addr.size() != 256 || wr_addr[wr_addr.size()-1] !== 32'h3FC) begin
      errors++;
      $display("FAIL max_writes got n=%0d bad=%0d want n=256 last=3fc", wr_addr.size(), bad);
    end
    checks++;
    if (o_words !== (ADDR_W+1)'(256) || o_done !== 1'b1 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL max_status got words=%0d done=%b err=%b want 256 1 0", o_words, o_done, o_err);
    end
  endtask

`ifdef MC_BOOT_CHKSUM_EN
  task automatic test_chksum();
    logic [7:0] s[$];
    bit ok, ok2;
    s = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    do_reset();
    send_stream(s, 0, 0, ok);
    wait_end(ok2);
    checks++;
    if ({o_done, o_err, o_cpu_rst_n} !== 3'b101) begin
      errors++;
      $display("FAIL chksum_good got %b%b%b want 101", o_done, o_err, o_cpu_rst_n);
    end
    s = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    do_reset();
    send_stream(s, 0, 0, ok);
    wait_end(ok2);
    checks++;
    if ({o_done, o_err, o_cpu_rst_n} !== 3'b010) begin
      errors++;
      $display("FAIL chksum_bad got %b%b%b want 010", o_done, o_err, o_cpu_rst_n);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic("stream", 0);
    test_basic("stall", 3);
    test_zero();
    test_overflow();
    test_abort();
    test_random(8);
    test_max();
`ifdef MC_BOOT_CHKSUM_EN
    test_chksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc_boot_loader.md
Name: mc_boot_loader

Overview:
- Upstream companion to the multi-cycle CPU top.
- Receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them into the CPU's unified memory starting at byte address 0.
- Holds the CPU in reset until the image is fully loaded, then releases it.
- Sits between the external byte source (UART receiver or testbench) and the memory write port.

Parameters:
- ADDR_W, 8, word-address width; the maximum image size is 2^ADDR_W words.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_byte  input  8  incoming byte.
- i_byte_valid  input  1  i_byte is valid this cycle.
- o_byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs when valid and ready are both high.
- o_mem_we  output  1  one-cycle memory write strobe.
- o_mem_addr  output  32  byte address, word aligned: BASE_ADDR + {word_idx, 2'b00}.
- o_mem_wdata  output  32  assembled word.
- o_cpu_rst_n  output  1  CPU reset, active low; low while loading.
- o_done  output  1  image loaded successfully (sticky).
- o_err  output  1  protocol error (sticky).
- o_words  output  ADDR_W+1  count of words written so far.

Behaviour:
- Reset values:
  - State S_LEN_HI.
  - o_byte_ready=1; o_mem_we=0; o_mem_addr=BASE_ADDR; o_mem_wdata=0.
  - o_cpu_rst_n=0; o_done=0; o_err=0; o_words=0.
  - Internal length=0, byte index=0, word index=0.
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N×4 data bytes, MSB first.
- States:
  - S_LEN_HI: accept a byte into len[15:8], then go to S_LEN_LO.
  - S_LEN_LO: accept a byte into len[7:0].
    - If N==0: go to S_DONE.
    - If N>2^ADDR_W: go to S_ERR.
    - Otherwise: go to S_DATA.
  - S_DATA: shift each accepted byte into the word register (word = {word[23:0], byte}) and increment the 2-bit byte index. On the 4th byte, go to S_WRITE.
  - S_WRITE: exactly one cycle.
    - o_mem_we=1, o_mem_addr=BASE_ADDR+4*word_idx, o_mem_wdata=word; o_byte_ready=0.
    - Increment word_idx and o_words.
    - If o_words (after increment) == N: go to S_DONE. Otherwise: return to S_DATA.
  - S_DONE: o_byte_ready=0; o_done=1; o_cpu_rst_n=1, registered, high from the first cycle in S_DONE. Terminal until reset.
  - S_ERR: o_byte_ready=0; o_err=1; o_cpu_rst_n stays 0. Terminal until reset.
- Handshake:
  - o_byte_ready is a registered function of state only; it never depends on i_byte_valid.
  - A byte is consumed only on a cycle where valid and ready are both high.
  - Valid low stalls indefinitely with no timeout.
- Latency: the memory write strobe occurs on the cycle after the 4th byte of a word is accepted. The minimum per-word cost is 5 cycles (4 accept + 1 write).
- o_mem_we is high only in S_WRITE; address and data hold their last value otherwise.
- Asynchronous reset mid-load aborts immediately:
  - Returns to S_LEN_HI and clears all counters.
  - o_cpu_rst_n goes low at once.
  - Words already written are not erased.
- Boundary: N==2^ADDR_W is legal; the last word is written at BASE_ADDR+4*(2^ADDR_W-1) and word_idx does not wrap before S_DONE.

Optional Feature:
- Macro: MC_BOOT_CHKSUM_EN.
- Defined:
  - After the final S_WRITE, go to S_CHK (o_byte_ready=1) instead of S_DONE. For N==0, S_LEN_LO also goes to S_CHK.
  - The loader keeps a running 8-bit XOR of every data byte accepted; the length bytes are excluded.
  - The byte accepted in S_CHK is compared against the XOR. Equal: go to S_DONE. Not equal: go to S_ERR.
  - For N==0, the expected checksum is 8'h00.
- Undefined: no S_CHK state and no checksum byte; the stream ends after the last data byte.

Test Plan:
- Stream 00 02 12 34 56 78 9A BC DE F0, valid always high:
  - mem writes (0x0, 0x12345678) and (0x4, 0x9ABCDEF0);
  - o_words=2; o_done=1; o_cpu_rst_n rises the cycle after the 2nd write.
- Same stream with valid deasserted for 3 cycles between every byte:
  - identical writes and values;
  - no byte is dropped or duplicated;
  - o_byte_ready stays 0 in each S_WRITE cycle.
- Stream 00 00: S_DONE immediately after LEN_LO with zero writes (CHKSUM_EN: after trailing 00).
- With ADDR_W=8, stream 01 01 (N=257):
  - o_err=1; no mem write; o_cpu_rst_n stays 0;
  - further bytes are ignored (ready=0).
- Assert i_rst_n low after 6 data bytes of a 2-word image, then release and send a full 1-word image AA BB CC DD:
  - single write (0x0, 0xAABBCCDD); o_words=1; o_done=1.
- MC_BOOT_CHKSUM_EN, stream 00 01 01 02 03 04 04: done (1^2^3^4=04).
- MC_BOOT_CHKSUM_EN, stream 00 01 01 02 03 04 05: o_err=1 and o_cpu_rst_n=0.
